control_sequencer: RTL and testbench

- Controller-sequencer for the SAP CPU. It consumes the 4-bit opcode from the instruction register's control output and drives every load/enable strobe on the shared 8-bit bus.
- A one-hot 6-state ring counter (T1..T6) steps fetch then execute. The opcode is decoded into a control word each T-state.
- The block sits between the instruction register and the PC, MAR, RAM, A, B, ALU and output register.

---
 rtl/sap_pkg.sv | 43 ++++
 rtl/ring_counter.sv | 25 ++
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller-sequencer: opcodes, T-state indices
// and control-word bit positions.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam int CW_W       = 12;
    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_OUT  = 1;
    localparam int CW_MAR_IN  = 2;
    localparam int CW_RAM_OUT = 3;
    localparam int CW_IR_IN   = 4;
    localparam int CW_IR_OUT  = 5;
    localparam int CW_A_IN    = 6;
    localparam int CW_A_OUT   = 7;
    localparam int CW_B_IN    = 8;
    localparam int CW_ALU_SUB = 9;
    localparam int CW_ALU_OUT = 10;
    localparam int CW_OUT_IN  = 11;

    typedef logic [CW_W-1:0] cw_t;

    localparam cw_t CW_NONE = '0;

    function automatic cw_t cw_bit(input int idx);
        cw_t w_cw;
        w_cw      = CW_NONE;
        w_cw[idx] = 1'b1;
        return w_cw;
    endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring counter: rotates each clock unless held, and can be
// forced back to the first state early with restart.
module ring_counter #(
    parameter int RING_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              restart,
    output logic [RING_W-1:0] state
);

    logic [RING_W-1:0] r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RING_W'(1);
        end else if (!hold) begin
            r_state <= restart ? RING_W'(1) : {r_state[RING_W-2:0], r_state[RING_W-1]};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/control_sequencer.sv
// SAP controller-sequencer: decodes opcode and T-state into bus strobes.
// Optional build macro CTRL_SKIP_NOP_EN ends instructions after their last strobe.
module control_sequencer
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RING_W   = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [RING_W-1:0]   tstate,
    output logic                pc_inc,
    output logic                pc_out,
    output logic                mar_in,
    output logic                ram_out,
    output logic                ir_in,
    output logic                ir_out,
    output logic                a_in,
    output logic                a_out,
    output logic                b_in,
    output logic                alu_sub,
    output logic                alu_out,
    output logic                out_in,
    output logic                halt,
    output logic                instr_done
);

    logic [RING_W-1:0] w_tstate;
    logic              r_halt;
    cw_t               w_cw;
    cw_t               w_cw_gated;
    logic              w_last;
    logic              w_restart;

    ring_counter #(.RING_W(RING_W)) u_ring (
        .clock   (clock),
        .reset   (reset),
        .hold    (r_halt),
        .restart (w_restart),
        .state   (w_tstate)
    );

    // HLT is seen in T4; the ring still steps once, so it freezes in T5.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_halt <= 1'b0;
        end else if (w_tstate[T4] && opcode == OP_HLT) begin
            r_halt <= 1'b1;
        end
    end

    always_comb begin
        w_cw   = CW_NONE;
        w_last = 1'b0;
        if (w_tstate[T1]) begin
            w_cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
        end else if (w_tstate[T2]) begin
            w_cw = cw_bit(CW_PC_INC);
        end else if (w_tstate[T3]) begin
            w_cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN);
        end else if (w_tstate[T4]) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB: w_cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
                OP_OUT:                 w_cw = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
                default:                w_cw = CW_NONE;
            endcase
        end else if (w_tstate[T5]) begin
            case (opcode)
                OP_LDA:         w_cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
                OP_ADD, OP_SUB: w_cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
                default:        w_cw = CW_NONE;
            endcase
        end else if (w_tstate[T6]) begin
            case (opcode)
                OP_ADD:  w_cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN);
                OP_SUB:  w_cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_ALU_SUB);
                default: w_cw = CW_NONE;
            endcase
        end
`ifdef CTRL_SKIP_NOP_EN
        case (opcode)
            OP_LDA:         w_last = w_tstate[T5];
            OP_ADD, OP_SUB: w_last = w_tstate[T6];
            OP_HLT:         w_last = 1'b0;
            default:        w_last = w_tstate[T4];
        endcase
`else
        w_last = w_tstate[T6];
`endif
    end

    assign w_cw_gated = r_halt ? CW_NONE : w_cw;
    assign w_restart  = w_last & ~r_halt;

    assign tstate     = w_tstate;
    assign halt       = r_halt;
    assign instr_done = w_last & ~r_halt;
    assign pc_inc     = w_cw_gated[CW_PC_INC];
    assign pc_out     = w_cw_gated[CW_PC_OUT];
    assign mar_in     = w_cw_gated[CW_MAR_IN];
    assign ram_out    = w_cw_gated[CW_RAM_OUT];
    assign ir_in      = w_cw_gated[CW_IR_IN];
    assign ir_out     = w_cw_gated[CW_IR_OUT];
    assign a_in       = w_cw_gated[CW_A_IN];
    assign a_out      = w_cw_gated[CW_A_OUT];
    assign b_in       = w_cw_gated[CW_B_IN];
    assign alu_sub    = w_cw_gated[CW_ALU_SUB];
    assign alu_out    = w_cw_gated[CW_ALU_OUT];
    assign out_in     = w_cw_gated[CW_OUT_IN];

    // Only one source may drive the shared bus in any cycle.
    a_bus_exclusive: assert property (@(posedge clock) disable iff (reset)
        $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an
// instruction-level reference model (honours CTRL_SKIP_NOP_EN when defined).
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_sub, alu_out, out_in;
    logic halt, instr_done;

    int n_checks = 0;
    int n_errors = 0;

    int m_t     = 1;
    bit m_halt  = 1'b0;
    bit m_valid = 1'b0;

    control_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .tstate     (tstate),
        .pc_inc     (pc_inc),
        .pc_out     (pc_out),
        .mar_in     (mar_in),
        .ram_out    (ram_out),
        .ir_in      (ir_in),
        .ir_out     (ir_out),
        .a_in       (a_in),
        .a_out      (a_out),
        .b_in       (b_in),
        .alu_sub    (alu_sub),
        .alu_out    (alu_out),
        .out_in     (out_in),
        .halt       (halt),
        .instr_done (instr_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Number of T-states the instruction occupies before returning to T1.
    function automatic int instr_len(input logic [3:0] op);
`ifdef CTRL_SKIP_NOP_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            4'hF:       return 7;
            default:    return 4;
        endcase
`else
        return (op == 4'hF) ? 7 : 6;
`endif
    endfunction

    // Order: pc_inc,pc_out,mar_in,ram_out,ir_in,ir_out,a_in,a_out,b_in,alu_sub,alu_out,out_in
    function automatic logic [11:0] model_strobes(input int t, input logic [3:0] op);
        logic e_pc_inc = 0, e_pc_out = 0, e_mar_in = 0, e_ram_out = 0, e_ir_in = 0, e_ir_out = 0;
        logic e_a_in = 0, e_a_out = 0, e_b_in = 0, e_alu_sub = 0, e_alu_out = 0, e_out_in = 0;
        bit is_arith = (op == 4'h1) || (op == 4'h2);
        if (t == 1) begin e_pc_out = 1; e_mar_in = 1; end
        if (t == 2) e_pc_inc = 1;
        if (t == 3) begin e_ram_out = 1; e_ir_in = 1; end
        if (t == 4 && (op == 4'h0 || is_arith)) begin e_ir_out = 1; e_mar_in = 1; end
        if (t == 4 && op == 4'hE) begin e_a_out = 1; e_out_in = 1; end
        if (t == 5 && op == 4'h0) begin e_ram_out = 1; e_a_in = 1; end
        if (t == 5 && is_arith) begin e_ram_out = 1; e_b_in = 1; end
        if (t == 6 && is_arith) begin e_alu_out = 1; e_a_in = 1; e_alu_sub = (op == 4'h2); end
        return {e_pc_inc, e_pc_out, e_mar_in, e_ram_out, e_ir_in, e_ir_out,
                e_a_in, e_a_out, e_b_in, e_alu_sub, e_alu_out, e_out_in};
    endfunction

    task automatic do_checks();
        logic [11:0] exp_s;
        if (!m_valid) return;
        exp_s = m_halt ? 12'h000 : model_strobes(m_t, opcode);
        check_eq("tstate", 32'(tstate), 32'(1 << (m_t - 1)));
        check_eq("halt", 32'(halt), 32'(m_halt));
        check_eq("strobes", 32'({pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
                                 a_in, a_out, b_in, alu_sub, alu_out, out_in}), 32'(exp_s));
        check_eq("instr_done", 32'(instr_done), 32'(!m_halt && m_t == instr_len(opcode)));
        check_eq("bus_excl", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
    endtask

    task automatic model_step();
        if (reset) begin
            m_t = 1; m_halt = 1'b0; m_valid = 1'b1;
        end else if (m_valid && !m_halt) begin
            if (m_t == 4 && opcode == 4'hF) begin
                m_halt = 1'b1; m_t = 5;
            end else if (m_t >= instr_len(opcode)) begin
                m_t = 1;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clock);
        do_checks();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op);
        int n = 0;
        opcode = op;
        do begin
            run_cycle();
            n++;
        end while (m_t != 1 && n < 12);
        check_eq("instr_bound", 32'(n < 12), 32'd1);
    endtask

    function automatic logic [3:0] pick_opcode();
        int r = $urandom_range(0, 11);
        case (r)
            0, 1:    return 4'h0;
            2, 3:    return 4'h1;
            4, 5:    return 4'h2;
            6, 7:    return 4'hE;
            8:       return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        reset  = 1'b1;
        opcode = 4'h0;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        check_eq("reset_tstate", 32'(tstate), 32'h1);
        check_eq("reset_halt", 32'(halt), 32'h0);

        run_instr(4'h1);
        run_instr(4'h2);
        run_instr(4'hE);
        run_instr(4'h7);

        // Reset in T5 of LDA must not leave a_in pulsing afterwards.
        opcode = 4'h0;
        repeat (4) run_cycle();
        check_eq("lda_t5", 32'(tstate), 32'h10);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        check_eq("lda_rst_tstate", 32'(tstate), 32'h1);
        check_eq("lda_rst_a_in", 32'(a_in), 32'h0);

        // Halt: freezes in T5 with opcode ignored until reset.
        opcode = 4'hF;
        repeat (4) run_cycle();
        check_eq("hlt_halt", 32'(halt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom_range(0, 15));
            run_cycle();
        end
        check_eq("hlt_frozen", 32'(tstate), 32'h10);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        check_eq("hlt_rst_tstate", 32'(tstate), 32'h1);
        check_eq("hlt_rst_halt", 32'(halt), 32'h0);

        // Random opcode stream with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            if (m_halt || m_t <= 3) opcode = pick_opcode();
            run_cycle();
        end
        reset = 1'b0;
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
